// File: rtl/implied_spread_engine_if.sv
// Bus bundle for implied_spread_engine: update request, input books and published spread book.
// With IMPLIED_OUT_EN defined it also carries the real spread book and the implied-out V book.
interface implied_spread_engine_if #(
    parameter int DEPTH   = 10,
    parameter int QTY_W   = 16,
    parameter int PRICE_W = 64,
    parameter int LVL_W   = QTY_W + 8 + PRICE_W,
    parameter int CNT_W   = $clog2(DEPTH + 1)
);
    logic                   update;
    logic [DEPTH*LVL_W-1:0] u_bid;
    logic [DEPTH*LVL_W-1:0] u_ask;
    logic [DEPTH*LVL_W-1:0] v_bid;
    logic [DEPTH*LVL_W-1:0] v_ask;
    logic [DEPTH*LVL_W-1:0] uv_bid;
    logic [DEPTH*LVL_W-1:0] uv_ask;
    logic [CNT_W-1:0]       bid_cnt;
    logic [CNT_W-1:0]       ask_cnt;
    logic                   busy;
    logic                   done;
`ifdef IMPLIED_OUT_EN
    logic [DEPTH*LVL_W-1:0] s_bid;
    logic [DEPTH*LVL_W-1:0] s_ask;
    logic [DEPTH*LVL_W-1:0] iv_bid;
    logic [DEPTH*LVL_W-1:0] iv_ask;

    modport master (
        output update, u_bid, u_ask, v_bid, v_ask, s_bid, s_ask,
        input  uv_bid, uv_ask, bid_cnt, ask_cnt, busy, done, iv_bid, iv_ask
    );
    modport slave (
        input  update, u_bid, u_ask, v_bid, v_ask, s_bid, s_ask,
        output uv_bid, uv_ask, bid_cnt, ask_cnt, busy, done, iv_bid, iv_ask
    );
`else
    modport master (
        output update, u_bid, u_ask, v_bid, v_ask,
        input  uv_bid, uv_ask, bid_cnt, ask_cnt, busy, done
    );
    modport slave (
        input  update, u_bid, u_ask, v_bid, v_ask,
        output uv_bid, uv_ask, bid_cnt, ask_cnt, busy, done
    );
`endif
endinterface

// File: rtl/implied_spread_engine.sv
// Sequential implied U-V spread book: snapshot both books, derive one level per cycle, publish atomically.
// Optional macro IMPLIED_OUT_EN also derives the implied-out V book from U and the real spread book.
module implied_spread_engine #(
    parameter int DEPTH   = 10,
    parameter int QTY_W   = 16,
    parameter int PRICE_W = 64,
    parameter int LVL_W   = QTY_W + 8 + PRICE_W,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input logic                    clk,
    input logic                    reset,
    implied_spread_engine_if.slave bus
);
    localparam int BUS_W = DEPTH * LVL_W;

    typedef enum logic [1:0] {IDLE, CAPTURE, CALC, PUBLISH} state_t;

    // Overflow of the widened difference shows up as disagreement between its top two bits.
    function automatic logic signed [PRICE_W-1:0] sat_sub(
        input logic signed [PRICE_W-1:0] a,
        input logic signed [PRICE_W-1:0] b
    );
        logic signed [PRICE_W:0] diff;
        diff = {a[PRICE_W-1], a} - {b[PRICE_W-1], b};
        if (diff[PRICE_W] != diff[PRICE_W-1])
            return diff[PRICE_W] ? {1'b1, {(PRICE_W-1){1'b0}}} : {1'b0, {(PRICE_W-1){1'b1}}};
        return diff[PRICE_W-1:0];
    endfunction

    function automatic logic [LVL_W-1:0] imply(input logic [LVL_W-1:0] a, input logic [LVL_W-1:0] b);
        logic [QTY_W-1:0] qa;
        logic [QTY_W-1:0] qb;
        qa = a[LVL_W-1 -: QTY_W];
        qb = b[LVL_W-1 -: QTY_W];
        if (qa == '0 || qb == '0)
            return '0;
        return {(qa < qb) ? qa : qb, 8'd0, sat_sub(a[PRICE_W-1:0], b[PRICE_W-1:0])};
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt, input logic [LVL_W-1:0] lvl);
        return (lvl[LVL_W-1 -: QTY_W] != '0) ? cnt + CNT_W'(1) : cnt;
    endfunction

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [BUS_W-1:0] u_bid_snap_q, u_bid_snap_d, u_ask_snap_q, u_ask_snap_d;
    logic [BUS_W-1:0] v_bid_snap_q, v_bid_snap_d, v_ask_snap_q, v_ask_snap_d;
    logic [BUS_W-1:0] wb_bid_q, wb_bid_d, wb_ask_q, wb_ask_d;
    logic [CNT_W-1:0] wcnt_bid_q, wcnt_bid_d, wcnt_ask_q, wcnt_ask_d;
    logic [BUS_W-1:0] uv_bid_q, uv_bid_d, uv_ask_q, uv_ask_d;
    logic [CNT_W-1:0] bid_cnt_q, bid_cnt_d, ask_cnt_q, ask_cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [LVL_W-1:0] bid_lvl, ask_lvl;
`ifdef IMPLIED_OUT_EN
    logic [BUS_W-1:0] s_bid_snap_q, s_bid_snap_d, s_ask_snap_q, s_ask_snap_d;
    logic [BUS_W-1:0] wiv_bid_q, wiv_bid_d, wiv_ask_q, wiv_ask_d;
    logic [BUS_W-1:0] iv_bid_q, iv_bid_d, iv_ask_q, iv_ask_d;
`endif

    // Snapshots are pure data: loaded only in CAPTURE, never reset.
    always_comb begin
        u_bid_snap_d = u_bid_snap_q;
        u_ask_snap_d = u_ask_snap_q;
        v_bid_snap_d = v_bid_snap_q;
        v_ask_snap_d = v_ask_snap_q;
`ifdef IMPLIED_OUT_EN
        s_bid_snap_d = s_bid_snap_q;
        s_ask_snap_d = s_ask_snap_q;
`endif
        if (state_q == CAPTURE) begin
            u_bid_snap_d = bus.u_bid;
            u_ask_snap_d = bus.u_ask;
            v_bid_snap_d = bus.v_bid;
            v_ask_snap_d = bus.v_ask;
`ifdef IMPLIED_OUT_EN
            s_bid_snap_d = bus.s_bid;
            s_ask_snap_d = bus.s_ask;
`endif
        end
    end

    always_ff @(posedge clk) begin
        u_bid_snap_q <= u_bid_snap_d;
        u_ask_snap_q <= u_ask_snap_d;
        v_bid_snap_q <= v_bid_snap_d;
        v_ask_snap_q <= v_ask_snap_d;
`ifdef IMPLIED_OUT_EN
        s_bid_snap_q <= s_bid_snap_d;
        s_ask_snap_q <= s_ask_snap_d;
`endif
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        idx_d      = idx_q;
        wb_bid_d   = wb_bid_q;
        wb_ask_d   = wb_ask_q;
        wcnt_bid_d = wcnt_bid_q;
        wcnt_ask_d = wcnt_ask_q;
        uv_bid_d   = uv_bid_q;
        uv_ask_d   = uv_ask_q;
        bid_cnt_d  = bid_cnt_q;
        ask_cnt_d  = ask_cnt_q;
        done_d     = 1'b0;
        bid_lvl    = imply(u_bid_snap_q[idx_q*LVL_W +: LVL_W], v_ask_snap_q[idx_q*LVL_W +: LVL_W]);
        ask_lvl    = imply(u_ask_snap_q[idx_q*LVL_W +: LVL_W], v_bid_snap_q[idx_q*LVL_W +: LVL_W]);
`ifdef IMPLIED_OUT_EN
        wiv_bid_d  = wiv_bid_q;
        wiv_ask_d  = wiv_ask_q;
        iv_bid_d   = iv_bid_q;
        iv_ask_d   = iv_ask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.update)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                idx_d      = '0;
                wcnt_bid_d = '0;
                wcnt_ask_d = '0;
                state_d    = CALC;
                if (bus.update)
                    pending_d = 1'b1;
            end
            CALC: begin
                wb_bid_d[idx_q*LVL_W +: LVL_W] = bid_lvl;
                wb_ask_d[idx_q*LVL_W +: LVL_W] = ask_lvl;
                wcnt_bid_d = bump(wcnt_bid_q, bid_lvl);
                wcnt_ask_d = bump(wcnt_ask_q, ask_lvl);
`ifdef IMPLIED_OUT_EN
                wiv_bid_d[idx_q*LVL_W +: LVL_W] =
                    imply(u_bid_snap_q[idx_q*LVL_W +: LVL_W], s_ask_snap_q[idx_q*LVL_W +: LVL_W]);
                wiv_ask_d[idx_q*LVL_W +: LVL_W] =
                    imply(u_ask_snap_q[idx_q*LVL_W +: LVL_W], s_bid_snap_q[idx_q*LVL_W +: LVL_W]);
`endif
                if (idx_q == CNT_W'(DEPTH - 1)) begin
                    idx_d   = '0;
                    state_d = PUBLISH;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
                if (bus.update)
                    pending_d = 1'b1;
            end
            PUBLISH: begin
                uv_bid_d  = wb_bid_q;
                uv_ask_d  = wb_ask_q;
                bid_cnt_d = wcnt_bid_q;
                ask_cnt_d = wcnt_ask_q;
`ifdef IMPLIED_OUT_EN
                iv_bid_d  = wiv_bid_q;
                iv_ask_d  = wiv_ask_q;
`endif
                done_d    = 1'b1;
                pending_d = 1'b0;
                // A request arriving in this very cycle is treated as pending and chains straight on.
                state_d   = (pending_q || bus.update) ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            idx_q      <= '0;
            wb_bid_q   <= '0;
            wb_ask_q   <= '0;
            wcnt_bid_q <= '0;
            wcnt_ask_q <= '0;
            uv_bid_q   <= '0;
            uv_ask_q   <= '0;
            bid_cnt_q  <= '0;
            ask_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IMPLIED_OUT_EN
            wiv_bid_q  <= '0;
            wiv_ask_q  <= '0;
            iv_bid_q   <= '0;
            iv_ask_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            wb_bid_q   <= wb_bid_d;
            wb_ask_q   <= wb_ask_d;
            wcnt_bid_q <= wcnt_bid_d;
            wcnt_ask_q <= wcnt_ask_d;
            uv_bid_q   <= uv_bid_d;
            uv_ask_q   <= uv_ask_d;
            bid_cnt_q  <= bid_cnt_d;
            ask_cnt_q  <= ask_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef IMPLIED_OUT_EN
            wiv_bid_q  <= wiv_bid_d;
            wiv_ask_q  <= wiv_ask_d;
            iv_bid_q   <= iv_bid_d;
            iv_ask_q   <= iv_ask_d;
`endif
        end
    end

    assign bus.uv_bid  = uv_bid_q;
    assign bus.uv_ask  = uv_ask_q;
    assign bus.bid_cnt = bid_cnt_q;
    assign bus.ask_cnt = ask_cnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
`ifdef IMPLIED_OUT_EN
    assign bus.iv_bid  = iv_bid_q;
    assign bus.iv_ask  = iv_ask_q;
`endif
endmodule
